hurricane_hbwif_serdes: RTL and testbench
=========================================

Name: hurricane_hbwif_serdes

Overview:
- 2:1 double-data-rate serializer (TX) and 1:2 deserializer (RX) for the Hurricane high-bandwidth wire interface (HBWIF) pad macro.
- Sits between the core's 2-bit-per-cycle parallel lanes and a differential pad pair in each direction.
- Both edges of the single clock carry one serial bit.
- The four phase-clock inputs of the original top are collapsed onto one clock.

Parameters:
- RX_RESET_VAL, 2'b01, value loaded into the RX parallel output register on reset.
- TX_RESET_VAL, 1'b0, value of io_tx_outp on reset.

Ports:
- clock  input  1  sole clock; both edges used; one parallel word per cycle.
- reset  input  1  asynchronous, active-high reset.
- io_tx_in  input  2  parallel TX word, sampled on rising edge.
- io_tx_outp  output  1  serial TX, positive leg.
- io_tx_outn  output  1  serial TX, negative leg; always ~io_tx_outp.
- io_rx_inp  input  1  serial RX, positive leg.
- io_rx_inn  input  1  serial RX, negative leg; ignored, no differential check.
- io_rx_out1  output  2  parallel RX word; bit0 = OutA (rising-edge sample), bit1 = OutB (falling-edge sample).

Behaviour:
- TX registers:
  - tx_in_d (2 bits) loads io_tx_in on each rising edge.
  - tx_outp_reg loads io_tx_in[0] on the same rising edge.
  - tx_outp_reg loads tx_in_d[1] on the following falling edge.
- TX output and order:
  - io_tx_outp = tx_outp_reg; io_tx_outn = ~tx_outp_reg, purely combinational.
  - Bit 0 is transmitted first, during the high phase. Bit 1 follows during the low phase.
  - Word presented before rising edge N: bit0 is on the pad from edge N, bit1 from the following falling edge.
  - Example: words 01,10,10,00,11 -> serial stream 1,0,0,1,0,1,0,0,1,1.
- RX capture:
  - rx_a samples io_rx_inp on the rising edge.
  - rx_b samples io_rx_inp on the falling edge.
  - rx_b_retime re-registers rx_b on the next rising edge, bringing it into the rising-edge domain.
- RX assembly:
  - On rising edge N+1, rx_out1_reg <= {rx_b_retime_source, rx_a}, pairing the rx_a taken at edge N with the rx_b taken at the falling edge between N and N+1.
  - io_rx_out1 = rx_out1_reg.
- RX latency: the first bit of a pair appears at io_rx_out1 one full cycle after its sample edge.
- Streaming: continuous; no valid/ready handshake. Every cycle produces one TX word consumed and one RX word emitted.
- Reset, asynchronous, all registers on both edges:
  - tx_in_d = 2'b00; tx_outp_reg = TX_RESET_VAL, so io_tx_outp=0 and io_tx_outn=1.
  - rx_a, rx_b and the retime register = 0.
  - rx_out1_reg = RX_RESET_VAL.
  - Deassertion takes effect at the next edge of either polarity.
  - Reset asserted mid-word drops the in-flight half-word; no partial bit is emitted after reset.
- Boundaries:
  - RX values changing faster than a half period are sampled, not filtered.
  - X on io_rx_inp propagates; no metastability protection is required.

Optional Feature:
- Macro HBWIF_LOOPBACK_EN.
- When defined: adds input io_loopback (1 bit).
  - When io_loopback=1, the RX samplers take tx_outp_reg internally instead of io_rx_inp.
  - TX pads keep driving normally.
  - io_loopback is sampled asynchronously and should only change while reset is high.
- When undefined: no port is added and the RX path always uses io_rx_inp.

Test Plan:
- Reset: assert reset mid-cycle -> immediately io_tx_outp=0, io_tx_outn=1, io_rx_out1=2'b01; hold after release until new data arrives.
- TX ordering: drive io_tx_in 00,01,10,10,00,11 on successive rising edges -> from the first rising edge of io_tx_outp, values at successive clock edges are 1,0,0,1,0,1,0,0,1,1.
- TX complement: random io_tx_in for 100 cycles -> io_tx_outn == ~io_tx_outp at all times; each word reappears bit0-then-bit1.
- RX ordering: drive io_rx_inp with 1 for the high phase and 0 for the low phase, then 0/1, then 1/1 -> io_rx_out1 = 2'b01, 2'b10, 2'b11 on consecutive rising edges, one cycle after each pair.
- Loopback (HBWIF_LOOPBACK_EN, io_loopback=1): drive io_tx_in 01,10,11,00 -> io_rx_out1 returns 01,10,11,00 after fixed latency, with io_rx_inp tied to 0.
- Async reset during traffic: pulse reset for a quarter period mid-stream -> all outputs jump to reset values without a clock edge; the stream resumes with the first word sampled after release.

Source files
------------

// File: rtl/hurricane_hbwif_serdes.sv
// 2:1 DDR serializer / 1:2 deserializer for the Hurricane HBWIF pad pair, single clock, both edges.
// Optional macro HBWIF_LOOPBACK_EN adds io_loopback to route the TX serial stream into the RX samplers.
module hurricane_hbwif_serdes #(
  parameter logic [1:0] RX_RESET_VAL = 2'b01,
  parameter logic       TX_RESET_VAL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] io_tx_in,
  output logic       io_tx_outp,
  output logic       io_tx_outn,
  input  logic       io_rx_inp,
  input  logic       io_rx_inn,
`ifdef HBWIF_LOOPBACK_EN
  input  logic       io_loopback,
`endif
  output logic [1:0] io_rx_out1
);

  logic       r_tx_in_d1;
  logic       r_tx_pos;
  logic       r_tx_neg;
  logic       r_rx_a;
  logic       r_rx_b;
  logic [1:0] r_rx_out1;
  logic       w_tx_out;
  logic       w_rx_in;
  logic       w_unused_rx_inn;

  // The negative leg carries no extra information; there is no differential check.
  assign w_unused_rx_inn = io_rx_inn;

  // The pad bit is the XOR of a rising-edge flop and a falling-edge flop. Each edge
  // pre-cancels the other flop's value, so the pad follows whichever flop toggled
  // last without putting the clock itself in the data path.
  assign w_tx_out   = r_tx_pos ^ r_tx_neg;
  assign io_tx_outp = w_tx_out;
  assign io_tx_outn = ~w_tx_out;

`ifdef HBWIF_LOOPBACK_EN
  assign w_rx_in = io_loopback ? w_tx_out : io_rx_inp;
`else
  assign w_rx_in = io_rx_inp;
`endif

  // Rising-edge stage: bit0 launch, bit1 hold, OutA capture, word assembly.
  // r_rx_out1[1] doubles as the retime flop that moves rx_b into this domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_in_d1 <= 1'b0;
      r_tx_pos   <= TX_RESET_VAL;
      r_rx_a     <= 1'b0;
      r_rx_out1  <= RX_RESET_VAL;
    end else begin
      r_tx_in_d1 <= io_tx_in[1];
      r_tx_pos   <= io_tx_in[0] ^ r_tx_neg;
      r_rx_a     <= w_rx_in;
      r_rx_out1  <= {r_rx_b, r_rx_a};
    end
  end

  // Falling-edge stage: bit1 launch, OutB capture.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      r_tx_neg <= 1'b0;
      r_rx_b   <= 1'b0;
    end else begin
      r_tx_neg <= r_tx_in_d1 ^ r_tx_pos;
      r_rx_b   <= w_rx_in;
    end
  end

  assign io_rx_out1 = r_rx_out1;

endmodule

// File: tb/tb_hurricane_hbwif_serdes.sv
// Directed bench for hurricane_hbwif_serdes: reset values, TX bit order, complement, RX pairing, async reset mid-stream.
module tb_hurricane_hbwif_serdes;

  logic       clock;
  logic       reset;
  logic [1:0] io_tx_in;
  logic       io_tx_outp;
  logic       io_tx_outn;
  logic       io_rx_inp;
  logic       io_rx_inn;
  logic [1:0] io_rx_out1;
`ifdef HBWIF_LOOPBACK_EN
  logic       io_loopback;
`endif

  int total;
  int bad;

  hurricane_hbwif_serdes dut (
    .clock      (clock),
    .reset      (reset),
    .io_tx_in   (io_tx_in),
    .io_tx_outp (io_tx_outp),
    .io_tx_outn (io_tx_outn),
    .io_rx_inp  (io_rx_inp),
    .io_rx_inn  (io_rx_inn),
`ifdef HBWIF_LOOPBACK_EN
    .io_loopback(io_loopback),
`endif
    .io_rx_out1 (io_rx_out1)
  );

  // Period 20: rising edges at 10, 30, 50, ...
  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [1:0] tx_words [6];
  logic       rx_a_tab [3];
  logic       rx_b_tab [3];
  logic [1:0] rx_exp   [3];
  logic [1:0] w;

  initial begin
    total = 0;
    bad   = 0;
    reset     = 1'b1;
    io_tx_in  = 2'b00;
    io_rx_inp = 1'b0;
    io_rx_inn = 1'b1;
`ifdef HBWIF_LOOPBACK_EN
    io_loopback = 1'b0;
`endif

    // Reset values appear without any clock edge.
    #3;
    chk("rst_outp", {1'b0, io_tx_outp}, 2'b00);
    chk("rst_outn", {1'b0, io_tx_outn}, 2'b01);
    chk("rst_rx",   io_rx_out1, 2'b01);
    #10 reset = 1'b0;
    #1;
    chk("rel_rx_hold", io_rx_out1, 2'b01);
    chk("rel_outp",    {1'b0, io_tx_outp}, 2'b00);

    // TX ordering: bit0 during the high phase, bit1 during the following low phase.
    tx_words = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      #2 io_tx_in = tx_words[i];
      @(posedge clock);
      #5;
      chk("tx_bit0", {1'b0, io_tx_outp}, {1'b0, tx_words[i][0]});
      chk("tx_outn_hi", {1'b0, io_tx_outn}, {1'b0, ~tx_words[i][0]});
      @(negedge clock);
      #5;
      chk("tx_bit1", {1'b0, io_tx_outp}, {1'b0, tx_words[i][1]});
      chk("tx_outn_lo", {1'b0, io_tx_outn}, {1'b0, ~tx_words[i][1]});
    end

    // Random words: complement always holds, bit0 then bit1.
    for (int i = 0; i < 100; i++) begin
      w = 2'($urandom_range(0, 3));
      #2 io_tx_in = w;
      @(posedge clock);
      #5;
      chk("rnd_bit0", {1'b0, io_tx_outp}, {1'b0, w[0]});
      chk("rnd_cmp_hi", {io_tx_outn, io_tx_outp}, {~w[0], w[0]});
      @(negedge clock);
      #5;
      chk("rnd_bit1", {1'b0, io_tx_outp}, {1'b0, w[1]});
      chk("rnd_cmp_lo", {io_tx_outn, io_tx_outp}, {~w[1], w[1]});
    end

    // RX ordering: A settles before the rising edge, B before the falling edge.
    rx_a_tab = '{1'b1, 1'b0, 1'b1};
    rx_b_tab = '{1'b0, 1'b1, 1'b1};
    rx_exp   = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      #3 io_rx_inp = rx_a_tab[i];
      @(posedge clock);
      #5 io_rx_inp = rx_b_tab[i];
      if (i > 0) chk("rx_pair", io_rx_out1, rx_exp[i-1]);
      @(negedge clock);
      #2;
    end
    #3 io_rx_inp = 1'b0;
    @(posedge clock);
    #5;
    chk("rx_pair_last", io_rx_out1, rx_exp[2]);

    // Async reset pulse mid-stream.
    @(negedge clock);
    #2 io_tx_in = 2'b11;
    #3 io_rx_inp = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #2 io_tx_in = 2'b11;
    @(posedge clock);
    #1;
    chk("pre_rst_outp", {1'b0, io_tx_outp}, 2'b01);
    chk("pre_rst_rx",   io_rx_out1, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_outp", {1'b0, io_tx_outp}, 2'b00);
    chk("mid_rst_outn", {1'b0, io_tx_outn}, 2'b01);
    chk("mid_rst_rx",   io_rx_out1, 2'b01);
    #4 reset = 1'b0;
    @(negedge clock);
    #5;
    chk("post_rst_drop", {1'b0, io_tx_outp}, 2'b00);
    #2 io_tx_in = 2'b10;
    @(posedge clock);
    #5;
    chk("resume_bit0", {1'b0, io_tx_outp}, 2'b00);
    chk("resume_rx",   io_rx_out1, 2'b10);
    @(negedge clock);
    #5;
    chk("resume_bit1", {1'b0, io_tx_outp}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
